// File: rtl/ray_gen.sv
// Primary-ray generator: walks an IMG_W x IMG_H raster and writes one origin/direction pair per pixel.
// Optional RAY_GEN_TAG_EN adds a pix_tag output carrying the linear pixel index of each write.
module ray_gen #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 48,
    parameter int D_BITS = 32,
    parameter int Q_BITS = 16,
    localparam int TAG_W = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0][D_BITS-1:0] cam_origin,
    input  logic [2:0][D_BITS-1:0] dir_base,
    input  logic [2:0][D_BITS-1:0] dir_dx,
    input  logic [2:0][D_BITS-1:0] dir_dy,
    input  logic                   out_full,
    output logic                   out_wr_en,
    output logic [2:0][D_BITS-1:0] origin,
    output logic [2:0][D_BITS-1:0] dir,
    output logic                   busy,
    output logic                   done
`ifdef RAY_GEN_TAG_EN
    ,
    output logic [TAG_W-1:0]       pix_tag
`endif
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    // Fractional position only matters to consumers; all arithmetic here is plain adds.
    if (Q_BITS < 0 || Q_BITS >= D_BITS) begin : g_bad_q_bits
        $error("ray_gen: Q_BITS must lie in [0, D_BITS)");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                   state;
    logic [XW-1:0]            x_cnt;
    logic [YW-1:0]            y_cnt;
    logic [2:0][D_BITS-1:0]   dx_q;
    logic [2:0][D_BITS-1:0]   dy_q;
    logic [2:0][D_BITS-1:0]   row_base;
    logic [2:0][D_BITS-1:0]   dir_step;
    logic [2:0][D_BITS-1:0]   row_next;
    logic                     wr;
    logic                     last_x;
    logic                     last_y;

    assign wr        = (state == S_EMIT) && !out_full;
    assign out_wr_en = wr;
    assign last_x    = (x_cnt == XW'(IMG_W - 1));
    assign last_y    = (y_cnt == YW'(IMG_H - 1));

    always_comb begin
        dir_step = '0;
        row_next = '0;
        for (int c = 0; c < 3; c++) begin
            dir_step[c] = dir[c] + dx_q[c];
            row_next[c] = row_base[c] + dy_q[c];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            x_cnt    <= '0;
            y_cnt    <= '0;
            origin   <= '0;
            dir      <= '0;
            row_base <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef RAY_GEN_TAG_EN
            pix_tag  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        origin   <= cam_origin;
                        dir      <= dir_base;
                        row_base <= dir_base;
                        dx_q     <= dir_dx;
                        dy_q     <= dir_dy;
                        x_cnt    <= '0;
                        y_cnt    <= '0;
                        busy     <= 1'b1;
                        state    <= S_EMIT;
`ifdef RAY_GEN_TAG_EN
                        pix_tag  <= '0;
`endif
                    end
                end
                S_EMIT: begin
                    if (wr) begin
`ifdef RAY_GEN_TAG_EN
                        pix_tag <= pix_tag + TAG_W'(1);
`endif
                        if (!last_x) begin
                            x_cnt <= x_cnt + XW'(1);
                            dir   <= dir_step;
                        end else if (!last_y) begin
                            // Row advance restarts from the stepped row base, not the running dir.
                            x_cnt    <= '0;
                            y_cnt    <= y_cnt + YW'(1);
                            row_base <= row_next;
                            dir      <= row_next;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ray_gen.sv
// Directed self-checking bench for ray_gen at IMG_W=4, IMG_H=2; expected rays come from base + x*dx + y*dy.
module tb_ray_gen;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [2:0][31:0]   cam_origin;
    logic [2:0][31:0]   dir_base;
    logic [2:0][31:0]   dir_dx;
    logic [2:0][31:0]   dir_dy;
    logic               out_full;
    logic               out_wr_en;
    logic [2:0][31:0]   origin;
    logic [2:0][31:0]   dir;
    logic               busy;
    logic               done;
`ifdef RAY_GEN_TAG_EN
    logic [2:0]         pix_tag;
`endif

    int vectors = 0;
    int errs    = 0;

    logic [2:0][31:0] e_org, e_base, e_dx, e_dy;

    ray_gen #(.IMG_W(4), .IMG_H(2)) dut (
        .clock      (clk),
        .reset      (rst_n),
        .start      (start),
        .cam_origin (cam_origin),
        .dir_base   (dir_base),
        .dir_dx     (dir_dx),
        .dir_dy     (dir_dy),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en),
        .origin     (origin),
        .dir        (dir),
        .busy       (busy),
        .done       (done)
`ifdef RAY_GEN_TAG_EN
        ,
        .pix_tag    (pix_tag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0][31:0] model_dir(input int x, input int y);
        logic [2:0][31:0] r;
        for (int c = 0; c < 3; c++)
            r[c] = e_base[c] + 32'(x) * e_dx[c] + 32'(y) * e_dy[c];
        return r;
    endfunction

    task automatic junk_inputs();
        cam_origin = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001};
        dir_base   = {32'h11111111, 32'h22222222, 32'h33333333};
        dir_dx     = {32'h00000123, 32'h00000456, 32'h00000789};
        dir_dy     = {32'h0000ABCD, 32'h0000BCDE, 32'h0000CDEF};
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first EMIT cycle.
    task automatic start_frame();
        cam_origin = e_org;
        dir_base   = e_base;
        dir_dx     = e_dx;
        dir_dy     = e_dy;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        junk_inputs();
        #1;
        check("busy_after_start", 96'(busy), 96'(1));
    endtask

    task automatic expect_writes(input int n, input int stall_at, input int restart_at,
                                 input bit check_done);
        int w = 0;
        int cyc = 0;
        bit stalled = 0;
        while (w < n && cyc < 100) begin
            check("wr_en_each_cycle", 96'(out_wr_en), 96'(1));
            if (out_wr_en) begin
                check("origin", origin, e_org);
                check("dir", dir, model_dir(w % 4, w / 4));
`ifdef RAY_GEN_TAG_EN
                check("pix_tag", 96'(pix_tag), 96'(w));
`endif
                w++;
                if (w == restart_at) start = 1'b1;
            end
            if (w < n) begin
                @(negedge clk);
                cyc++;
                start = 1'b0;
                if (w == stall_at && !stalled) begin
                    stalled  = 1;
                    out_full = 1'b1;
                    repeat (5) begin
                        #1;
                        check("no_wr_while_full", 96'(out_wr_en), 96'(0));
                        check("busy_while_full", 96'(busy), 96'(1));
                        @(negedge clk);
                    end
                    out_full = 1'b0;
                end
                #1;
            end
        end
        check("write_count", 96'(w), 96'(n));
        if (check_done) begin
            @(negedge clk);
            #1;
            check("done_pulse", 96'(done), 96'(1));
            check("busy_at_done", 96'(busy), 96'(0));
            check("no_wr_at_done", 96'(out_wr_en), 96'(0));
            @(negedge clk);
            #1;
            check("done_one_cycle", 96'(done), 96'(0));
            check("no_wr_after_frame", 96'(out_wr_en), 96'(0));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        out_full = 1'b0;
        junk_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("rst_wr_en", 96'(out_wr_en), 96'(0));
        check("rst_busy", 96'(busy), 96'(0));
        check("rst_done", 96'(done), 96'(0));
        check("rst_origin", origin, 96'(0));
        check("rst_dir", dir, 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_no_wr", 96'(out_wr_en), 96'(0));

        // Base frame
        e_org  = {32'h0, 32'h0, 32'h0};
        e_base = {32'h00010000, 32'h0, 32'h0};
        e_dx   = {32'h0, 32'h0, 32'h00008000};
        e_dy   = {32'h0, 32'h00008000, 32'h0};
        start_frame();
        expect_writes(8, -1, -1, 1);

        // Backpressure after the 2nd write; 3rd ray must be (0x10000,0,0x10000)
        e_org = {32'h00030000, 32'h00020000, 32'h00010000};
        start_frame();
        expect_writes(8, 2, -1, 1);
        check("third_ray_literal", model_dir(2, 0), {32'h00010000, 32'h0, 32'h00010000});

        // Wrap of dir.x across the signed boundary
        e_org  = {32'h0, 32'h0, 32'h0};
        e_base = {32'h0, 32'h0, 32'h7FFF8000};
        e_dx   = {32'h0, 32'h0, 32'h00008000};
        e_dy   = {32'h0, 32'h00008000, 32'h0};
        start_frame();
        check("wrap_ray0_x", 96'(dir[0]), 96'(32'h7FFF8000));
        @(negedge clk);
        #1;
        check("wrap_ray1_x", 96'(dir[0]), 96'(32'h80000000));
        check("wrap_ray1_wr", 96'(out_wr_en), 96'(1));
        repeat (6) @(negedge clk);
        @(negedge clk);
        #1;
        check("wrap_done", 96'(done), 96'(1));
        @(negedge clk);
        #1;

        // Start pulse mid-frame with different inputs must be ignored
        e_org  = {32'h00000C00, 32'h00000B00, 32'h00000A00};
        e_base = {32'hFFFF0000, 32'h00004000, 32'h00001000};
        e_dx   = {32'h00000010, 32'h00000020, 32'h00000030};
        e_dy   = {32'h00000100, 32'h00000200, 32'h00000300};
        start_frame();
        expect_writes(8, -1, 3, 1);

        // Reset after the 3rd write abandons the frame
        start_frame();
        expect_writes(3, -1, -1, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en", 96'(out_wr_en), 96'(0));
        check("midrst_busy", 96'(busy), 96'(0));
        check("midrst_done", 96'(done), 96'(0));
        check("midrst_origin", origin, 96'(0));
        check("midrst_dir", dir, 96'(0));
        @(negedge clk);
        #1;
        check("midrst_hold_wr", 96'(out_wr_en), 96'(0));
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("postrst_idle_wr", 96'(out_wr_en), 96'(0));
        e_org  = {32'h00000007, 32'h00000006, 32'h00000005};
        e_base = {32'h00020000, 32'hFFFF8000, 32'h00004000};
        e_dx   = {32'h00000000, 32'h00000000, 32'hFFFFC000};
        e_dy   = {32'h00000000, 32'h00010000, 32'h00000000};
        start_frame();
        expect_writes(8, -1, -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
